// File: rtl/conv_tap_sequencer_pkg.sv
// Shared definitions for the convolution tap sequencer: FSM state encoding,
// select/accumulator widths and the final tap index.
package conv_tap_sequencer_pkg;

  localparam int SEL_W = 3;
  localparam int TAPS  = 2 ** SEL_W;
  localparam int ACC_W = 4;

  localparam logic [SEL_W-1:0] LAST_TAP = SEL_W'(TAPS - 1);

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_DONE = 2'd2
  } state_t;

  // Contribution of one tap to the running sum, widened to accumulator size.
  function automatic logic [ACC_W-1:0] tap_term(input logic mux_bit, input logic kern_bit);
    return {{(ACC_W-1){1'b0}}, mux_bit & kern_bit};
  endfunction

endpackage

// File: rtl/conv_tap_sequencer_if.sv
// Handshake and mux-side signal bundle for the convolution tap sequencer.
// slave = the sequencer itself, master = the upstream/downstream/mux side.
interface conv_tap_sequencer_if;
  import conv_tap_sequencer_pkg::*;

  logic             in_valid;
  logic             in_ready;
  logic [TAPS-1:0]  in_win;
  logic [TAPS-1:0]  in_kern;
  logic [TAPS-1:0]  mux_data;
  logic [SEL_W-1:0] mux_sel;
  logic             mux_out;
  logic             out_valid;
  logic             out_ready;
  logic [ACC_W-1:0] out_sum;

  modport slave (
    input  in_valid, in_win, in_kern, mux_out, out_ready,
    output in_ready, mux_data, mux_sel, out_valid, out_sum
  );

  modport master (
    output in_valid, in_win, in_kern, mux_out, out_ready,
    input  in_ready, mux_data, mux_sel, out_valid, out_sum
  );

endinterface

// File: rtl/conv_tap_sequencer.sv
// Convolution tap sequencer: latches a window/kernel pair, walks the external
// 8:1 mux select through taps 0..7 and accumulates mux_out & kern[tap] into a
// 0..8 dot product returned over a valid/ready handshake.
// Optional macro CONV_B2B_EN: retire the result and load the next pair in the
// same DONE cycle, skipping IDLE.
module conv_tap_sequencer
  import conv_tap_sequencer_pkg::*;
(
  input logic                  clk,
  input logic                  rst_n,
  conv_tap_sequencer_if.slave  bus
);

  state_t           state_r;
  logic             in_ready_r;
  logic             in_ready_s;
  logic             out_valid_r;
  logic [ACC_W-1:0] out_sum_r;
  logic [ACC_W-1:0] acc_r;
  logic [ACC_W-1:0] acc_next_s;
  logic [SEL_W-1:0] mux_sel_r;
  logic [TAPS-1:0]  mux_data_r;
  logic [TAPS-1:0]  kern_r;

  // Running sum including the tap currently presented on the mux select.
  always_comb begin
    acc_next_s = acc_r + tap_term(bus.mux_out, kern_r[mux_sel_r]);
  end

  // Input readiness: only IDLE accepts, unless back-to-back lets DONE follow out_ready.
  always_comb begin
    in_ready_s = in_ready_r;
`ifdef CONV_B2B_EN
    if (state_r == ST_DONE) begin
      in_ready_s = bus.out_ready;
    end else begin
      in_ready_s = in_ready_r;
    end
`endif
  end

  // Sequencer FSM with all outputs registered.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r     <= ST_IDLE;
      in_ready_r  <= 1'b1;
      out_valid_r <= 1'b0;
      out_sum_r   <= {ACC_W{1'b0}};
      acc_r       <= {ACC_W{1'b0}};
      mux_sel_r   <= {SEL_W{1'b0}};
      mux_data_r  <= {TAPS{1'b0}};
      kern_r      <= {TAPS{1'b0}};
    end else begin
      case (state_r)
        ST_IDLE: begin
          if (bus.in_valid) begin
            mux_data_r <= bus.in_win;
            kern_r     <= bus.in_kern;
            mux_sel_r  <= {SEL_W{1'b0}};
            acc_r      <= {ACC_W{1'b0}};
            in_ready_r <= 1'b0;
            state_r    <= ST_RUN;
          end
        end
        ST_RUN: begin
          acc_r <= acc_next_s;
          if (mux_sel_r != LAST_TAP) begin
            mux_sel_r <= mux_sel_r + 1'b1;
          end else begin
            out_sum_r   <= acc_next_s;
            out_valid_r <= 1'b1;
            state_r     <= ST_DONE;
          end
        end
        ST_DONE: begin
          if (bus.out_ready) begin
            out_valid_r <= 1'b0;
`ifdef CONV_B2B_EN
            if (bus.in_valid) begin
              mux_data_r <= bus.in_win;
              kern_r     <= bus.in_kern;
              mux_sel_r  <= {SEL_W{1'b0}};
              acc_r      <= {ACC_W{1'b0}};
              state_r    <= ST_RUN;
            end else begin
              in_ready_r <= 1'b1;
              state_r    <= ST_IDLE;
            end
`else
            in_ready_r <= 1'b1;
            state_r    <= ST_IDLE;
`endif
          end
        end
        default: begin
          state_r     <= ST_IDLE;
          in_ready_r  <= 1'b1;
          out_valid_r <= 1'b0;
        end
      endcase
    end
  end

  assign bus.in_ready  = in_ready_s;
  assign bus.out_valid = out_valid_r;
  assign bus.out_sum   = out_sum_r;
  assign bus.mux_sel   = mux_sel_r;
  assign bus.mux_data  = mux_data_r;

endmodule
